scratch_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port scratch memory among three requesters: histogram builder (0), CDF accumulator (1) and divider memory controller (2). It registers the winning command onto the memory port, tracks in-flight reads through the fixed memory read latency, and returns read data with a per-requester valid strobe. An optional lock input keeps one requester in front during paired accesses, such as the two CDF line reads per divide.

---
 rtl/scratch_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_scratch_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter
//   Round-robin arbiter sharing the single-port scratch memory among three
//   requesters (0 = histogram builder, 1 = CDF accumulator, 2 = divider
//   memory controller). Registers the winning command onto the memory port,
//   tracks reads through the fixed memory latency and returns read data with
//   a per-requester valid strobe. A lock keeps one requester in front for
//   paired accesses.
// Ports
//   clk, reset          clock, async active-high reset
//   req/req_we/req_lock per-requester request, write flag, lock
//   req_addr/req_wdata  per-requester command, slice i = requester i
//   gnt                 combinational one-hot grant
//   rd_valid/rd_data    registered read return
//   mem_*               registered memory command, mem_rdata return
//   busy                access issued or read in flight
module scratch_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          req,
   input  logic [2:0]          req_we,
   input  logic [2:0]          req_lock,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wdata,
   output logic [2:0]          gnt,
   output logic [2:0]          rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   function automatic logic [1:0] nxt3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   logic [1:0]  last_q, last_d;
   logic        lock_vld_q, lock_vld_d;
   logic [1:0]  lock_id_q, lock_id_d;
   logic [1:0]  win, p1, p2;
   logic        xfer, lock_hold;

   logic [RD_LAT:0]      vld_pipe_q;
   logic [RD_LAT:0][1:0] id_pipe_q;
   logic [2:0]           rd_valid_q;
   logic [DATA_W-1:0]    rd_data_q;
   logic                 mem_en_q, mem_we_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [DATA_W-1:0]    mem_wdata_q;

   // Grant: lock owner first while it still requests, else rotate from last.
   always_comb begin
      gnt       = '0;
      win       = last_q;
      p1        = nxt3(last_q);
      p2        = nxt3(p1);
      lock_hold = lock_vld_q & req[lock_id_q];
      if (lock_hold)          win = lock_id_q;
      else if (req[p1])       win = p1;
      else if (req[p2])       win = p2;
      else                    win = last_q;
      if (!reset && req[win]) gnt[win] = 1'b1;
      xfer = |gnt;
   end

   // A transfer re-arms or drops the lock according to the winner's lock bit;
   // an owner that stops requesting loses the lock immediately. last only
   // advances when the lock was not steering the grant.
   always_comb begin
      last_d     = last_q;
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (xfer) begin
         if (!lock_hold) last_d = win;
         lock_vld_d = req_lock[win];
         lock_id_d  = win;
      end else if (lock_vld_q && !req[lock_id_q]) begin
         lock_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q      <= 2'd2;
         lock_vld_q  <= 1'b0;
         lock_id_q   <= 2'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         rd_valid_q  <= '0;
         rd_data_q   <= '0;
      end else begin
         last_q     <= last_d;
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
         // address/wdata hold between transfers
         mem_en_q   <= xfer;
         mem_we_q   <= xfer & req_we[win];
         if (xfer) begin
            mem_addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
            mem_wdata_q <= req_wdata[win*DATA_W +: DATA_W];
         end
         // stage 0 lines up with mem_en; stage RD_LAT with valid mem_rdata
         vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], xfer & ~req_we[win]};
         id_pipe_q  <= {id_pipe_q[RD_LAT-1:0], win};
         rd_valid_q <= '0;
         if (vld_pipe_q[RD_LAT]) begin
            rd_valid_q[id_pipe_q[RD_LAT]] <= 1'b1;
            rd_data_q                     <= mem_rdata;
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = mem_en_q | (|vld_pipe_q);

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
module tb_scratch_mem_arbiter;
   localparam int LAT = 2;

   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A: default latency, scoreboard-checked
   logic [2:0]  req = '0, req_we = '0, req_lock = '0;
   logic [47:0] req_addr = '0;
   logic [95:0] req_wdata = '0;
   logic [2:0]  gnt, rd_valid;
   logic [31:0] rd_data, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;
   logic        mem_en, mem_we, busy;

   scratch_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
      .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

   // instance B: RD_LAT=4, checked cycle by cycle
   logic [2:0]  reqB = '0, gntB, rd_validB;
   logic [31:0] rd_dataB, mem_wdataB;
   logic [15:0] mem_addrB;
   logic        mem_enB, mem_weB, busyB;

   scratch_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(4)) dutB (
      .clk(clk), .reset(reset), .req(reqB), .req_we(3'b000), .req_lock(3'b000),
      .req_addr(48'd5), .req_wdata(96'd0), .gnt(gntB), .rd_valid(rd_validB),
      .rd_data(rd_dataB), .mem_en(mem_enB), .mem_we(mem_weB), .mem_addr(mem_addrB),
      .mem_wdata(mem_wdataB), .mem_rdata(32'h0000BEEF), .busy(busyB));

   // write-first memory model with LAT-cycle read delay
   function automatic logic [31:0] init_val(input logic [7:0] a);
      case (a)
         8'd64:  return 32'h1234;
         8'd65:  return 32'h5678;
         8'd10:  return 32'hA0;
         8'd11:  return 32'hA1;
         8'd12:  return 32'hA2;
         8'd20:  return 32'hB0;
         8'd21:  return 32'hB1;
         8'd127: return 32'hDEAD;
         default: return 32'h0;
      endcase
   endfunction
   logic [31:0] mem [0:255];
   logic        wr  [0:255];
   logic [31:0] line [0:LAT-1];
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         wr[mem_addr[7:0]]  <= 1'b1;
      end
      line[0] <= (wr[mem_addr[7:0]] === 1'b1) ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
      for (int k = 1; k < LAT; k++) line[k] <= line[k-1];
   end
   assign mem_rdata = line[LAT-1];

   int n_checks = 0, n_errors = 0;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct { int cyc; int id; } gexp_t;
   typedef struct { int cyc; logic we; logic [15:0] a; logic [31:0] d; } cexp_t;
   typedef struct { int cyc; int id; logic [31:0] d; } rexp_t;
   gexp_t gq[$];
   cexp_t cq[$];
   rexp_t rq[$];

   // expected transfer in the current cycle
   task automatic xp(input int i, input logic we, input logic [15:0] a,
                     input logic [31:0] d, input logic [31:0] rd);
      gq.push_back('{cyc, i});
      cq.push_back('{cyc + 1, we, a, d});
      if (!we) rq.push_back('{cyc + 2 + LAT, i, rd});
   endtask

   task automatic rq_set(input int i, input logic r, input logic we, input logic lk,
                         input logic [15:0] a, input logic [31:0] d);
      req[i] = r; req_we[i] = we; req_lock[i] = lk;
      req_addr[i*16 +: 16] = a; req_wdata[i*32 +: 32] = d;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // monitor
   gexp_t ge; cexp_t ce; rexp_t re;
   always @(negedge clk) if (!reset) begin
      if (gnt != 3'b000) begin
         if (gq.size() == 0) chk("gnt_unexpected", {125'd0, gnt}, 128'd0);
         else begin
            ge = gq.pop_front();
            chk("gnt", {64'd0, 32'(cyc), 29'd0, gnt}, {64'd0, 32'(ge.cyc), 29'd0, 3'(1 << ge.id)});
         end
      end
      if (mem_en) begin
         if (cq.size() == 0) chk("cmd_unexpected", 128'd1, 128'd0);
         else begin
            ce = cq.pop_front();
            chk("cmd", {32'(cyc), 15'd0, mem_we, mem_addr, mem_wdata},
                       {32'(ce.cyc), 15'd0, ce.we, ce.a, ce.d});
         end
      end
      if (rd_valid != 3'b000) begin
         if (rq.size() == 0) chk("rd_unexpected", {125'd0, rd_valid}, 128'd0);
         else begin
            re = rq.pop_front();
            chk("rd", {32'(cyc), 29'd0, rd_valid, rd_data},
                      {32'(re.cyc), 29'd0, 3'(1 << re.id), re.d});
         end
      end
   end

   task automatic chk_idle(input string nm);
      chk(nm, {gnt, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy}, '0);
   endtask

   initial begin
      // reset state with requests pending
      req = 3'b111;
      repeat (2) @(posedge clk);
      #1 chk_idle("reset_state");
      req = 3'b000;

      // single read from requester 0
      tick(); reset = 1'b0;
      rq_set(0, 1, 0, 0, 16'd64, 32'h0); xp(0, 0, 16'd64, 32'h0, 32'h1234);
      tick(); rq_set(0, 0, 0, 0, 16'd64, 32'h0);
      repeat (6) tick();

      // fresh reset, then all three requesting for 6 cycles
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 3; i++) rq_set(i, 1, 0, 0, 16'(10 + i), 32'(32'h100 + i));
      for (int k = 0; k < 6; k++) begin
         xp(k % 3, 0, 16'(10 + k % 3), 32'(32'h100 + k % 3), 32'(32'hA0 + k % 3));
         tick();
      end
      req = 3'b000;
      repeat (8) tick();

      // locked pair from requester 2 while 0 and 1 contend
      rq_set(2, 1, 0, 1, 16'd64, 32'h0); xp(2, 0, 16'd64, 32'h0, 32'h1234);
      tick();
      rq_set(0, 1, 0, 0, 16'd20, 32'h0); rq_set(1, 1, 0, 0, 16'd21, 32'h0);
      rq_set(2, 1, 0, 0, 16'd65, 32'h0); xp(2, 0, 16'd65, 32'h0, 32'h5678);
      tick(); rq_set(2, 0, 0, 0, 16'd0, 32'h0); xp(0, 0, 16'd20, 32'h0, 32'hB0);
      tick(); rq_set(0, 0, 0, 0, 16'd0, 32'h0); xp(1, 0, 16'd21, 32'h0, 32'hB1);
      tick(); req = 3'b000;
      repeat (8) tick();

      // write then read back the same address
      rq_set(1, 1, 1, 0, 16'd127, 32'hCAFE); xp(1, 1, 16'd127, 32'hCAFE, 32'h0);
      tick(); rq_set(1, 1, 0, 0, 16'd127, 32'h0); xp(1, 0, 16'd127, 32'h0, 32'hCAFE);
      tick(); req = 3'b000;
      repeat (8) tick();

      // reset with three reads in flight
      rq_set(0, 1, 0, 0, 16'd10, 32'h0); xp(0, 0, 16'd10, 32'h0, 32'hA0);
      tick(); rq_set(0, 0, 0, 0, 16'd0, 32'h0);
      rq_set(1, 1, 0, 0, 16'd11, 32'h0); xp(1, 0, 16'd11, 32'h0, 32'hA1);
      tick(); rq_set(1, 0, 0, 0, 16'd0, 32'h0);
      rq_set(2, 1, 0, 0, 16'd12, 32'h0); xp(2, 0, 16'd12, 32'h0, 32'hA2);
      tick();
      for (int i = 0; i < 3; i++) rq_set(i, 1, 0, 0, 16'(10 + i), 32'h0);
      reset = 1'b1;
      #1 chk_idle("mid_reset");
      gq.delete(); cq.delete(); rq.delete();
      tick(); reset = 1'b0; xp(0, 0, 16'd10, 32'h0, 32'hA0);
      tick(); req = 3'b000;
      repeat (10) tick();

      // RD_LAT=4 instance: single read, cycle-exact busy/rd_valid
      reqB = 3'b001;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k == 0) chk("B_gnt", {125'd0, gntB}, 128'd1);
         chk($sformatf("B_busy_c%0d", k), {127'd0, busyB}, {127'd0, (k >= 1 && k <= 5)});
         chk($sformatf("B_rdv_c%0d", k), {125'd0, rd_validB}, {125'd0, (k == 6) ? 3'b001 : 3'b000});
         if (k == 6) chk("B_rd_data", {96'd0, rd_dataB}, {96'd0, 32'h0000BEEF});
         tick(); reqB = 3'b000;
      end

      for (int t = 0; t < 20 && (gq.size() + cq.size() + rq.size()) != 0; t++) tick();
      chk("drain", 128'(gq.size() + cq.size() + rq.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
